keypad_debounce: RTL and testbench
==================================

KEYPAD_DEBOUNCE -- requirements
Module: keypad_debounce

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, default 4, consecutive identical synchronized samples needed to accept a press or release (legal range 2..255).
REQ-002 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: key_raw  input  12  raw, asynchronous, bouncy keypad lines; bit i = digit i (i=0..9), bit 10 = '*', bit 11 = '#'; 1 = pressed.
REQ-005 SHALL have port: key_char  output  12  debounced one-hot key code, held for the whole accepted press; feeds the lock FSM's character input directly.
REQ-006 SHALL have port: key_strobe  output  1  one-cycle pulse in the first cycle key_char becomes nonzero.
REQ-007 SHALL have port: key_error  output  1  one-cycle pulse when more than one key is seen pressed at once.
REQ-008 SHALL drive all outputs straight from flops, with no combinational path from key_raw.

Function
REQ-009 SHALL pass key_raw through a 2-flop synchronizer; "sample" means the second-stage value, one per clock edge.
REQ-010 SHALL implement FSM states IDLE, CHECK, HELD, RELEASE, with an 8-bit stability counter.
REQ-011 IDLE: sample zero -> stay; one-hot sample -> capture it as candidate, count=1, go CHECK; multi-bit sample -> pulse key_error, go RELEASE.
REQ-012 CHECK: sample equals candidate -> count+1; the edge on which count reaches DEBOUNCE_CYCLES -> go HELD, set key_char=candidate, set key_strobe=1.
REQ-013 CHECK: zero sample -> go IDLE; different one-hot sample -> go IDLE, no strobe; multi-bit sample -> pulse key_error, go RELEASE.
REQ-014 HELD: key_char holds candidate while sample equals candidate; any other sample -> key_char=0, count=0, go RELEASE, no error pulse.
REQ-015 RELEASE: zero sample -> count+1; nonzero sample -> count=0; count reaching DEBOUNCE_CYCLES -> go IDLE.
REQ-016 SHALL deassert key_strobe and key_error on the clock after each assertion; at most one strobe per accepted press.
REQ-017 Press latency: with key_raw stable from edge E0, key_strobe and key_char are visible after edge E0+DEBOUNCE_CYCLES+1 (6 edges for the default).
REQ-018 Release latency: key_char returns to 0 after the third edge following key_raw leaving the held code.
REQ-019 SHALL never emit a key_char value that has more than one bit set.
REQ-020 SHALL reach a new strobe only via RELEASE then IDLE, so release chatter never produces a second strobe.

Reset
REQ-021 reset high SHALL clear synchronizer flops, counter, candidate, key_char, key_strobe and key_error asynchronously, and force IDLE.
REQ-022 reset asserted mid-press SHALL drop key_char to 0 at once; if the key is still held after reset deasserts, it SHALL be re-acquired per REQ-011/012 with one new strobe.

Verification
REQ-023 Reset: reset=1 for 2 cycles, key_raw=12'h020 -> key_char=0, key_strobe=0, key_error=0 throughout reset.
REQ-024 Clean press: key_raw=12'h020 for 10 cycles, then 0 (default parameter) -> one key_strobe pulse 6 edges after apply; key_char=12'h020 until 3 edges after release, then 0.
REQ-025 Bounce: key_raw toggles 12'h004/0 every cycle for 6 cycles, then holds 12'h004 for 10 cycles -> exactly one strobe, 6 edges after the steady hold begins.
REQ-026 Short press: key_raw=12'h800 for 3 cycles -> no strobe, key_char stays 0.
REQ-027 Multi-key: key_raw=12'h003 for 8 cycles, then 0 for 6 cycles, then 12'h800 for 10 cycles -> one key_error pulse, no strobe for 12'h003; one strobe with key_char=12'h800 afterwards.
REQ-028 Release chatter and reset: key_raw=12'h002 held, then 0/12'h002 alternating every cycle for 6 cycles -> no second strobe; a further 12'h002 press with reset pulsed while HELD -> key_char=0 immediately, one new strobe after reset deasserts.

Source files
------------

// File: rtl/keypad_debounce.sv
// keypad_debounce
//   Debounces a 12-line keypad (digits 0..9, '*', '#') into a one-hot key code.
//   A single key is accepted once it has been sampled steadily for
//   DEBOUNCE_CYCLES clocks. Every accepted press must be followed by a clean
//   release before another key can be accepted.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   key_raw    raw keypad lines (bit i = digit i, bit 10 = '*', bit 11 = '#')
//   key_char   debounced one-hot key code, held while the key is held
//   key_strobe one-cycle pulse when key_char first becomes nonzero
//   key_error  one-cycle pulse when more than one key is seen at once
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no key; waiting for the first nonzero sample
// CHECK   | single key seen; counting identical samples
// HELD    | key accepted; key_char driven until the sample changes
// RELEASE | waiting for DEBOUNCE_CYCLES consecutive all-zero samples

module keypad_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] key_raw,
    output logic [11:0] key_char,
    output logic        key_strobe,
    output logic        key_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

    logic [11:0] sync_1;
    logic [11:0] sync_2;
    state_t      state;
    state_t      state_nxt;
    logic [7:0]  count;
    logic [7:0]  count_nxt;
    logic [7:0]  count_inc;
    logic [11:0] cand;
    logic [11:0] cand_nxt;
    logic [11:0] char_nxt;
    logic        strobe_nxt;
    logic        error_nxt;
    logic        is_zero;
    logic        is_onehot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= key_raw;
            sync_2 <= sync_1;
        end
    end

    assign is_zero   = (sync_2 == 12'd0);
    // x & (x-1) clears the lowest set bit; zero result means at most one bit.
    assign is_onehot = !is_zero && ((sync_2 & (sync_2 - 12'd1)) == 12'd0);
    assign count_inc = count + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            cand       <= '0;
            key_char   <= '0;
            key_strobe <= 1'b0;
            key_error  <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            cand       <= cand_nxt;
            key_char   <= char_nxt;
            key_strobe <= strobe_nxt;
            key_error  <= error_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        cand_nxt   = cand;
        char_nxt   = key_char;
        strobe_nxt = 1'b0;
        error_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (is_onehot) begin
                    cand_nxt  = sync_2;
                    count_nxt = 8'd1;
                    state_nxt = CHECK;
                end else if (!is_zero) begin
                    error_nxt = 1'b1;
                    count_nxt = 8'd0;
                    state_nxt = RELEASE;
                end
            end
            CHECK: begin
                if (sync_2 == cand) begin
                    count_nxt = count_inc;
                    if (count_inc == DB_LIMIT) begin
                        char_nxt   = cand;
                        strobe_nxt = 1'b1;
                        state_nxt  = HELD;
                    end
                end else if (is_zero || is_onehot) begin
                    // A different single key restarts acquisition from IDLE.
                    state_nxt = IDLE;
                end else begin
                    error_nxt = 1'b1;
                    count_nxt = 8'd0;
                    state_nxt = RELEASE;
                end
            end
            HELD: begin
                if (sync_2 != cand) begin
                    char_nxt  = '0;
                    count_nxt = 8'd0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (is_zero) begin
                    count_nxt = count_inc;
                    if (count_inc == DB_LIMIT) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    count_nxt = 8'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_debounce.sv
module tb_keypad_debounce;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] key_raw = 12'h020;
    logic [11:0] key_char;
    logic        key_strobe;
    logic        key_error;

    int checks = 0;
    int errors = 0;

    keypad_debounce #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_raw    (key_raw),
        .key_char   (key_char),
        .key_strobe (key_strobe),
        .key_error  (key_error)
    );

    always #5 clk = ~clk;

    // Reference model: samples arrive two edges late; acceptance, error and
    // release rules are applied directly to that sample stream.
    localparam int M_WAIT = 0, M_COUNTING = 1, M_ACCEPTED = 2, M_QUIET = 3;
    logic [11:0] m_dly[2];
    int          m_mode;
    int          m_run;
    logic [11:0] m_cand;
    logic [11:0] m_char;
    logic        m_strobe;
    logic        m_err;

    always @(posedge clk or posedge reset) begin : model_step
        logic [11:0] s;
        int          ones;
        if (reset) begin
            m_dly[0] = '0; m_dly[1] = '0;
            m_mode = M_WAIT; m_run = 0; m_cand = '0;
            m_char = '0; m_strobe = 1'b0; m_err = 1'b0;
        end else begin
            s = m_dly[1];
            m_dly[1] = m_dly[0];
            m_dly[0] = key_raw;
            ones = $countones(s);
            m_strobe = 1'b0;
            m_err = 1'b0;
            if (m_mode == M_WAIT) begin
                if (ones == 1) begin
                    m_cand = s; m_run = 1; m_mode = M_COUNTING;
                end else if (ones > 1) begin
                    m_err = 1'b1; m_run = 0; m_mode = M_QUIET;
                end
            end else if (m_mode == M_COUNTING) begin
                if (s == m_cand) begin
                    m_run++;
                    if (m_run == DB) begin
                        m_char = m_cand; m_strobe = 1'b1; m_mode = M_ACCEPTED;
                    end
                end else if (ones <= 1) begin
                    m_mode = M_WAIT;
                end else begin
                    m_err = 1'b1; m_run = 0; m_mode = M_QUIET;
                end
            end else if (m_mode == M_ACCEPTED) begin
                if (s != m_cand) begin
                    m_char = '0; m_run = 0; m_mode = M_QUIET;
                end
            end else begin
                m_run = (ones == 0) ? m_run + 1 : 0;
                if (m_run == DB) m_mode = M_WAIT;
            end
        end
    end

    task automatic test_reset();
        #1 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({key_char, key_strobe, key_error} !== 14'd0) begin
                errors++;
                $display("FAIL reset cyc %0d: got char=%h stb=%b err=%b, want all zero",
                         i, key_char, key_strobe, key_error);
            end
        end
        reset = 1'b0;
        key_raw = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({key_char, key_strobe, key_error} !== {m_char, m_strobe, m_err}) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %h/%b/%b want %h/%b/%b",
                         i, key_char, key_strobe, key_error, m_char, m_strobe, m_err);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [11:0] q[$];
        int strobes = 0, strobe_at = -1;
        for (int i = 0; i < 10; i++) q.push_back(12'h020);
        for (int i = 0; i < 10; i++) q.push_back(12'h000);
        for (int i = 0; i < q.size(); i++) begin
            key_raw = q[i];
            @(negedge clk);
            checks++;
            if ({key_char, key_strobe, key_error} !== {m_char, m_strobe, m_err}) begin
                errors++;
                $display("FAIL clean_press cyc %0d: got %h/%b/%b want %h/%b/%b",
                         i, key_char, key_strobe, key_error, m_char, m_strobe, m_err);
            end
            if (key_strobe) begin strobes++; strobe_at = i; end
            if (i == 11) begin
                checks++;
                if (key_char !== 12'h020) begin
                    errors++;
                    $display("FAIL clean_hold: got %h want 020", key_char);
                end
            end
            if (i == 12) begin
                checks++;
                if (key_char !== 12'h000) begin
                    errors++;
                    $display("FAIL clean_release_latency: got %h want 000", key_char);
                end
            end
        end
        checks++;
        if (strobes != 1 || strobe_at != 5) begin
            errors++;
            $display("FAIL clean_strobe: got %0d strobes at cyc %0d, want 1 at cyc 5",
                     strobes, strobe_at);
        end
    endtask

    task automatic test_bounce();
        logic [11:0] q[$];
        int strobes = 0, strobe_at = -1;
        for (int i = 0; i < 6; i++) q.push_back((i % 2 == 0) ? 12'h004 : 12'h000);
        for (int i = 0; i < 10; i++) q.push_back(12'h004);
        for (int i = 0; i < 10; i++) q.push_back(12'h000);
        for (int i = 0; i < q.size(); i++) begin
            key_raw = q[i];
            @(negedge clk);
            checks++;
            if ({key_char, key_strobe, key_error} !== {m_char, m_strobe, m_err}) begin
                errors++;
                $display("FAIL bounce cyc %0d: got %h/%b/%b want %h/%b/%b",
                         i, key_char, key_strobe, key_error, m_char, m_strobe, m_err);
            end
            if (key_strobe) begin strobes++; strobe_at = i; end
        end
        checks++;
        if (strobes != 1 || strobe_at != 11) begin
            errors++;
            $display("FAIL bounce_strobe: got %0d strobes at cyc %0d, want 1 at cyc 11",
                     strobes, strobe_at);
        end
    endtask

    task automatic test_short_press();
        logic [11:0] q[$];
        int strobes = 0, nonzero = 0;
        for (int i = 0; i < 3; i++) q.push_back(12'h800);
        for (int i = 0; i < 12; i++) q.push_back(12'h000);
        for (int i = 0; i < q.size(); i++) begin
            key_raw = q[i];
            @(negedge clk);
            checks++;
            if ({key_char, key_strobe, key_error} !== {m_char, m_strobe, m_err}) begin
                errors++;
                $display("FAIL short_press cyc %0d: got %h/%b/%b want %h/%b/%b",
                         i, key_char, key_strobe, key_error, m_char, m_strobe, m_err);
            end
            if (key_strobe) strobes++;
            if (key_char != 0) nonzero++;
        end
        checks++;
        if (strobes != 0 || nonzero != 0) begin
            errors++;
            $display("FAIL short_none: got %0d strobes, %0d nonzero cycles, want 0/0",
                     strobes, nonzero);
        end
    endtask

    task automatic test_multi_key();
        logic [11:0] q[$];
        int strobes = 0, errs = 0, strobe_at = -1;
        logic [11:0] char_at_strobe = '0;
        for (int i = 0; i < 8; i++) q.push_back(12'h003);
        for (int i = 0; i < 6; i++) q.push_back(12'h000);
        for (int i = 0; i < 10; i++) q.push_back(12'h800);
        for (int i = 0; i < 10; i++) q.push_back(12'h000);
        for (int i = 0; i < q.size(); i++) begin
            key_raw = q[i];
            @(negedge clk);
            checks++;
            if ({key_char, key_strobe, key_error} !== {m_char, m_strobe, m_err}) begin
                errors++;
                $display("FAIL multi_key cyc %0d: got %h/%b/%b want %h/%b/%b",
                         i, key_char, key_strobe, key_error, m_char, m_strobe, m_err);
            end
            if (key_strobe) begin strobes++; strobe_at = i; char_at_strobe = key_char; end
            if (key_error) errs++;
        end
        checks++;
        if (errs != 1 || strobes != 1 || strobe_at != 19 || char_at_strobe !== 12'h800) begin
            errors++;
            $display("FAIL multi_summary: got err=%0d stb=%0d at %0d char=%h, want 1/1 at 19 char=800",
                     errs, strobes, strobe_at, char_at_strobe);
        end
    endtask

    task automatic test_chatter_reset();
        logic [11:0] q[$];
        int strobes = 0;
        for (int i = 0; i < 10; i++) q.push_back(12'h002);
        for (int i = 0; i < 6; i++) q.push_back((i % 2 == 0) ? 12'h000 : 12'h002);
        for (int i = 0; i < 10; i++) q.push_back(12'h000);
        for (int i = 0; i < q.size(); i++) begin
            key_raw = q[i];
            @(negedge clk);
            checks++;
            if ({key_char, key_strobe, key_error} !== {m_char, m_strobe, m_err}) begin
                errors++;
                $display("FAIL chatter cyc %0d: got %h/%b/%b want %h/%b/%b",
                         i, key_char, key_strobe, key_error, m_char, m_strobe, m_err);
            end
            if (key_strobe) strobes++;
        end
        checks++;
        if (strobes != 1) begin
            errors++;
            $display("FAIL chatter_strobes: got %0d want 1", strobes);
        end

        key_raw = 12'h002;
        repeat (8) @(negedge clk);
        checks++;
        if (key_char !== 12'h002) begin
            errors++;
            $display("FAIL reset_pre_held: got %h want 002", key_char);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({key_char, key_strobe, key_error} !== 14'd0) begin
            errors++;
            $display("FAIL reset_async: got %h/%b/%b want 000/0/0",
                     key_char, key_strobe, key_error);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        strobes = 0;
        for (int i = 0; i < 22; i++) begin
            key_raw = (i < 12) ? 12'h002 : 12'h000;
            @(negedge clk);
            checks++;
            if ({key_char, key_strobe, key_error} !== {m_char, m_strobe, m_err}) begin
                errors++;
                $display("FAIL reacquire cyc %0d: got %h/%b/%b want %h/%b/%b",
                         i, key_char, key_strobe, key_error, m_char, m_strobe, m_err);
            end
            if (key_strobe) strobes++;
        end
        checks++;
        if (strobes != 1) begin
            errors++;
            $display("FAIL reacquire_strobes: got %0d want 1", strobes);
        end
    endtask

    task automatic test_random();
        int bad_onehot = 0;
        for (int seg = 0; seg < 150; seg++) begin
            int kind = $urandom_range(0, 4);
            int len  = $urandom_range(1, 10);
            logic [11:0] onehot = 12'(1) << $urandom_range(0, 11);
            logic [11:0] other  = 12'(1) << $urandom_range(0, 11);
            for (int c = 0; c < len; c++) begin
                case (kind)
                    0: key_raw = '0;
                    1: key_raw = onehot;
                    2: key_raw = onehot | other;
                    3: key_raw = (c % 2 == 0) ? onehot : 12'h000;
                    default: key_raw = 12'($urandom);
                endcase
                @(negedge clk);
                checks++;
                if ({key_char, key_strobe, key_error} !== {m_char, m_strobe, m_err}) begin
                    errors++;
                    $display("FAIL random seg %0d cyc %0d: got %h/%b/%b want %h/%b/%b",
                             seg, c, key_char, key_strobe, key_error, m_char, m_strobe, m_err);
                end
                if ($countones(key_char) > 1) bad_onehot++;
            end
        end
        checks++;
        if (bad_onehot != 0) begin
            errors++;
            $display("FAIL random_onehot: got %0d multi-bit key_char cycles want 0", bad_onehot);
        end
        key_raw = '0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_press();
        test_multi_key();
        test_chatter_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
